// File: rtl/fetch_unit_pkg.sv
// Shared types and default geometry for the instruction fetch unit.
// Imported by the fetch top and its interface so widths stay in one place.
package fetch_unit_pkg;

   localparam int PC_W    = 10;
   localparam int INSTR_W = 9;
   localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;
   localparam int LAST_PC = 63;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_PRIME = 2'd1,
      FS_RUN   = 2'd2,
      FS_HALT  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction-memory read port plus the delivery port to decode.
// The master side is the fetch unit; the slave side is memory and decode.
interface fetch_unit_if #(
   parameter int PC_W    = fetch_unit_pkg::PC_W,
   parameter int INSTR_W = fetch_unit_pkg::INSTR_W
);
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic [PC_W-1:0]    instr_pc;

   modport master (
      output imem_addr,
      input  imem_rdata,
      output instr_valid,
      output instr,
      output instr_pc
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      input  instr_valid,
      input  instr,
      input  instr_pc
   );
endinterface

// File: rtl/fetch_unit_sat_counter16.sv
// 16-bit event counter with synchronous clear and saturation at all-ones.
// Clear wins over enable so a restart always lands on zero.
module sat_counter16 (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        en,
   input  logic        clr,
   output logic [15:0] count
);

   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && (count != 16'hFFFF))
         count <= count + 16'd1;
   end

endmodule

// File: rtl/fetch_unit.sv
// Single-issue fetch unit: one-cycle-latency instruction memory, branch squash
// of the wrong-path fetch, halt detection, and delivered/run cycle counters.
module fetch_unit #(
   parameter int                 PC_W       = fetch_unit_pkg::PC_W,
   parameter int                 INSTR_W    = fetch_unit_pkg::INSTR_W,
   parameter logic [INSTR_W-1:0] HALT_INSTR = fetch_unit_pkg::HALT_INSTR,
   parameter int                 LAST_PC    = fetch_unit_pkg::LAST_PC
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [PC_W-1:0]  pc_in,
   input  logic             redirect,
   fetch_unit_if.master     bus,
   output logic             done,
   output logic [15:0]      instr_count,
   output logic [15:0]      cycle_count
);
   import fetch_unit_pkg::*;

   localparam logic [1:0] IDLE  = FS_IDLE;
   localparam logic [1:0] PRIME = FS_PRIME;
   localparam logic [1:0] RUN   = FS_RUN;
   localparam logic [1:0] HALT  = FS_HALT;

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic            inflight_v;
   logic [PC_W-1:0] inflight_pc;
   logic            squash;

   logic active;
   logic deliver;
   logic halt_hit;

   assign active   = (state == PRIME) || (state == RUN);
   assign deliver  = (state == RUN) && inflight_v && !squash;
   assign halt_hit = deliver && ((bus.imem_rdata == HALT_INSTR) ||
                                 (inflight_pc == PC_W'(LAST_PC)));

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = PRIME;
         PRIME:   state_nxt = start ? PRIME : RUN;
         RUN: begin
            if (start)
               state_nxt = PRIME;
            else if (halt_hit)
               state_nxt = HALT;
         end
         HALT:    if (start) state_nxt = PRIME;
         default: state_nxt = IDLE;
      endcase
   end

   // A restart or halt drops the in-flight fetch; otherwise the current
   // pc_in becomes next cycle's delivery, squashed after a taken branch.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         inflight_v  <= 1'b0;
         inflight_pc <= '0;
         squash      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start) begin
            inflight_v <= 1'b0;
            squash     <= 1'b0;
         end else if ((state == PRIME) || ((state == RUN) && !halt_hit)) begin
            inflight_v  <= 1'b1;
            inflight_pc <= pc_in;
            squash      <= (state == RUN) && redirect && !squash;
         end else begin
            inflight_v <= 1'b0;
            squash     <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.imem_addr   = active ? pc_in : '0;
      bus.instr_valid = deliver;
      bus.instr       = (state == RUN) ? bus.imem_rdata : '0;
      bus.instr_pc    = (state == RUN) ? inflight_pc : '0;
      done            = (state == HALT);
   end

   sat_counter16 u_instr_cnt (
      .CLK   (CLK),
      .RST_N (RST_N),
      .en    (deliver),
      .clr   (start),
      .count (instr_count)
   );

   sat_counter16 u_cycle_cnt (
      .CLK   (CLK),
      .RST_N (RST_N),
      .en    (active),
      .clr   (start),
      .count (cycle_count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an external PC register and one-cycle memory,
// a program-level model of what decode must see, and literal pin-down checks.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int PW = 10;
   localparam int IW = 9;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          start = 1'b0;
   logic          redirect = 1'b0;
   logic [PW-1:0] pc = '0;
   logic [PW-1:0] start_addr = '0;
   logic [PW-1:0] target = '0;
   logic          done;
   logic [15:0]   instr_count;
   logic [15:0]   cycle_count;

   logic [IW-1:0] mem [0:1023];

   int vectors = 0;
   int miscompares = 0;

   fetch_unit_if #(.PC_W(PW), .INSTR_W(IW)) bus ();

   fetch_unit #(.PC_W(PW), .INSTR_W(IW), .HALT_INSTR(9'h1FF), .LAST_PC(63)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .start       (start),
      .pc_in       (pc),
      .redirect    (redirect),
      .bus         (bus),
      .done        (done),
      .instr_count (instr_count),
      .cycle_count (cycle_count)
   );

   always #5 CLK = ~CLK;

   // Program counter owned by the surrounding core: start beats redirect beats +1.
   always @(posedge CLK) begin
      if (start)         pc <= start_addr;
      else if (redirect) pc <= target;
      else               pc <= pc + 1'b1;
   end

   always @(posedge CLK) bus.imem_rdata <= mem[bus.imem_addr];

   // Program-level model: mode 0 idle, 1 running, 2 halted; one outstanding
   // fetch (address + killed flag) that is presented on the following cycle.
   int            m_mode;
   logic          m_fv, m_kill;
   logic [PW-1:0] m_fpc;
   logic [15:0]   m_icnt, m_ccnt;

   logic          exp_valid;
   logic [IW-1:0] exp_instr;
   logic [PW-1:0] exp_pc, exp_addr;
   logic          exp_done;

   always_comb begin
      exp_valid = RST_N && (m_mode == 1) && m_fv && !m_kill;
      exp_instr = mem[m_fpc];
      exp_pc    = m_fpc;
      exp_addr  = (RST_N && (m_mode == 1)) ? pc : '0;
      exp_done  = RST_N && (m_mode == 2);
   end

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_mode <= 0; m_fv <= 1'b0; m_kill <= 1'b0; m_fpc <= '0;
         m_icnt <= '0; m_ccnt <= '0;
      end else if (start) begin
         m_mode <= 1; m_fv <= 1'b0; m_kill <= 1'b0;
         m_icnt <= '0; m_ccnt <= '0;
      end else if (m_mode == 1) begin
         m_ccnt <= (m_ccnt == 16'hFFFF) ? m_ccnt : m_ccnt + 16'd1;
         if (exp_valid) m_icnt <= (m_icnt == 16'hFFFF) ? m_icnt : m_icnt + 16'd1;
         if (exp_valid && ((exp_instr == HALT_INSTR) || (exp_pc == PW'(LAST_PC)))) begin
            m_mode <= 2; m_fv <= 1'b0; m_kill <= 1'b0;
         end else begin
            m_fv   <= 1'b1;
            m_fpc  <= pc;
            m_kill <= redirect && m_fv && !m_kill;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      check("instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
      check("imem_addr", 32'(bus.imem_addr), 32'(exp_addr));
      check("done", 32'(done), 32'(exp_done));
      check("instr_count", 32'(instr_count), 32'(m_icnt));
      check("cycle_count", 32'(cycle_count), 32'(m_ccnt));
      if (exp_valid) begin
         check("instr", 32'(bus.instr), 32'(exp_instr));
         check("instr_pc", 32'(bus.instr_pc), 32'(exp_pc));
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_at(input logic [PW-1:0] addr);
      start = 1'b1;
      start_addr = addr;
      tick();
      start = 1'b0;
   endtask

   task automatic run_until_pc(input logic [PW-1:0] p);
      for (int i = 0; i < 200; i++) begin
         if (exp_valid && (exp_pc == p)) break;
         tick();
      end
      check("reach_pc", 32'(bus.instr_pc), 32'(p));
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200; i++) begin
         if (done) break;
         tick();
      end
      check("wait_done", 32'(done), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = IW'(i);

      // Reset state
      #12;
      check("rst_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_addr", 32'(bus.imem_addr), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_icnt", 32'(instr_count), 32'd0);
      @(posedge CLK); #3; RST_N = 1'b1;
      tick(); tick();

      // Straight line from 0 until the last address forces halt
      start_at(10'd0);
      check("prime_valid", 32'(bus.instr_valid), 32'd0);
      tick();
      check("first_valid", 32'(bus.instr_valid), 32'd1);
      check("first_pc", 32'(bus.instr_pc), 32'd0);
      tick();
      check("second_pc", 32'(bus.instr_pc), 32'd1);
      check("second_instr", 32'(bus.instr), 32'd1);
      wait_done();
      check("line_icnt", 32'(instr_count), 32'd64);
      check("line_ccnt", 32'(cycle_count), 32'd65);
      tick(); tick();
      check("halt_frozen", 32'(instr_count), 32'd64);

      // Taken branch at 5 to 20
      start_at(10'd0);
      run_until_pc(10'd5);
      redirect = 1'b1; target = 10'd20;
      tick();
      redirect = 1'b0;
      check("squash_bubble", 32'(bus.instr_valid), 32'd0);
      tick();
      check("target_valid", 32'(bus.instr_valid), 32'd1);
      check("target_pc", 32'(bus.instr_pc), 32'd20);
      wait_done();
      check("branch_icnt", 32'(instr_count), 32'd50);

      // Halt encoding at address 8
      mem[8] = HALT_INSTR;
      start_at(10'd0);
      wait_done();
      check("halt_icnt", 32'(instr_count), 32'd9);
      mem[8] = 9'd8;

      // Redirect raised during the squash bubble is ignored
      start_at(10'd0);
      run_until_pc(10'd5);
      redirect = 1'b1; target = 10'd20;
      tick();
      target = 10'd40;
      tick();
      redirect = 1'b0;
      check("no_double_squash", 32'(bus.instr_valid), 32'd1);
      check("no_double_pc", 32'(bus.instr_pc), 32'd20);
      tick();
      check("late_target_pc", 32'(bus.instr_pc), 32'd40);
      wait_done();

      // Restart and redirect in the same cycle: restart wins
      start_at(10'd0);
      run_until_pc(10'd5);
      start = 1'b1; start_addr = 10'd0; redirect = 1'b1; target = 10'd20;
      tick();
      start = 1'b0; redirect = 1'b0;
      check("restart_icnt", 32'(instr_count), 32'd0);
      check("restart_ccnt", 32'(cycle_count), 32'd0);
      tick();
      check("restart_valid", 32'(bus.instr_valid), 32'd1);
      check("restart_pc", 32'(bus.instr_pc), 32'd0);
      check("restart_ccnt1", 32'(cycle_count), 32'd1);

      // Reset mid-run at pc 12, then start at 30
      run_until_pc(10'd12);
      RST_N = 1'b0;
      #1;
      check("midrst_valid", 32'(bus.instr_valid), 32'd0);
      check("midrst_addr", 32'(bus.imem_addr), 32'd0);
      check("midrst_icnt", 32'(instr_count), 32'd0);
      check("midrst_ccnt", 32'(cycle_count), 32'd0);
      #2; RST_N = 1'b1;
      tick(); tick();
      check("post_rst_idle", 32'(bus.instr_valid), 32'd0);
      start_at(10'd30);
      tick();
      check("resume_pc", 32'(bus.instr_pc), 32'd30);
      check("resume_icnt", 32'(instr_count), 32'd0);
      check("resume_ccnt", 32'(cycle_count), 32'd1);
      wait_done();
      check("resume_total", 32'(instr_count), 32'd34);

      // Loop 0..62 long enough to saturate both counters
      start_at(10'd0);
      for (int i = 0; i < 67000; i++) begin
         if (exp_valid && (exp_pc == 10'd62)) begin
            redirect = 1'b1; target = 10'd0;
         end else begin
            redirect = 1'b0;
         end
         tick();
      end
      redirect = 1'b0;
      check("sat_icnt", 32'(instr_count), 32'hFFFF);
      check("sat_ccnt", 32'(cycle_count), 32'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
